// File: rtl/cv32e40p_ft_fault_manager.sv
// Fault tracking and recovery controller downstream of the triple-modular voter.
// Tracks per-replica leaky error counters, requests resyncs and halts on uncorrectable events.
module cv32e40p_ft_fault_manager #(
    parameter int DATA_WIDTH   = 32,
    parameter int CNT_WIDTH    = 4,
    parameter int THRESHOLD    = 4,
    parameter int DECAY_PERIOD = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] c_i,
    input  logic [DATA_WIDTH-1:0] winner_i,
    input  logic                  fault_i,
    input  logic                  resync_ack_i,
    input  logic                  clear_i,
    output logic                  resync_req_o,
    output logic [1:0]            faulty_replica_o,
    output logic [2:0]            permanent_o,
    output logic                  halt_o,
    output logic [15:0]           fault_count_o
);

    // state  | meaning
    // S_IDLE | no recovery action pending
    // S_REQ  | resync requested, waiting for ack
    // S_HALT | uncorrectable condition, waiting for clear
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam int TW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [TW-1:0]        TIMER_MAX = TW'(DECAY_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] THR       = CNT_WIDTH'(THRESHOLD);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q [3];
    logic [CNT_WIDTH-1:0] cnt_d [3];
    logic [2:0]           perm_q, perm_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [1:0]           fr_q, fr_d;
    logic [15:0]          fc_q, fc_d;

    logic [2:0] m;
    logic       onehot;
    logic       ev_clean;
    logic       ev_single;
    logic       ev_unc;

    assign m[0]   = (a_i != winner_i);
    assign m[1]   = (b_i != winner_i);
    assign m[2]   = (c_i != winner_i);
    assign onehot = (m == 3'b001) || (m == 3'b010) || (m == 3'b100);

    // A single mismatch the voter did not flag is a voter inconsistency, hence uncorrectable.
    assign ev_clean  = valid_i && (m == 3'b000) && !fault_i;
    assign ev_single = valid_i && onehot && fault_i;
    assign ev_unc    = valid_i && !ev_clean && !ev_single;

    always_comb begin
        cnt_d   = cnt_q;
        perm_d  = perm_q;
        timer_d = timer_q;
        fr_d    = fr_q;
        fc_d    = fc_q;
        if (clear_i) begin
            for (int k = 0; k < 3; k++) cnt_d[k] = '0;
            perm_d  = '0;
            timer_d = '0;
        end else if (ev_single) begin
            timer_d = '0;
            if (fc_q != 16'hFFFF) fc_d = fc_q + 16'd1;
            for (int k = 0; k < 3; k++) begin
                if (m[k]) begin
                    fr_d = 2'(k);
                    if (!perm_q[k]) begin
                        if (cnt_q[k] != CNT_MAX) cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
                        if (cnt_d[k] >= THR) perm_d[k] = 1'b1;
                    end
                end
            end
        end else if (ev_unc) begin
            if (fc_q != 16'hFFFF) fc_d = fc_q + 16'd1;
        end else if (ev_clean) begin
            if (timer_q == TIMER_MAX) begin
                timer_d = '0;
                for (int k = 0; k < 3; k++) begin
                    if (!perm_q[k] && cnt_q[k] != '0) cnt_d[k] = cnt_q[k] - CNT_WIDTH'(1);
                end
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ev_unc)         state_d = S_HALT;
                    else if (ev_single) state_d = S_REQ;
                end
                S_REQ: begin
                    // A fresh fault arriving with the ack keeps the request up without a gap.
                    if (ev_unc)                         state_d = S_HALT;
                    else if (resync_ack_i && !ev_single) state_d = S_IDLE;
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
            perm_q  <= '0;
            timer_q <= '0;
            fr_q    <= 2'd3;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
            perm_q  <= perm_d;
            timer_q <= timer_d;
            fr_q    <= fr_d;
            fc_q    <= fc_d;
        end
    end

    assign resync_req_o     = (state_q == S_REQ);
    assign halt_o           = (state_q == S_HALT);
    assign faulty_replica_o = fr_q;
    assign permanent_o      = perm_q;
    assign fault_count_o    = fc_q;

endmodule

// File: tb/tb_cv32e40p_ft_fault_manager.sv
// Directed self-checking bench for the fault manager with default parameters.
module tb_cv32e40p_ft_fault_manager;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] a = '0, b = '0, c = '0, winner = '0;
    logic        fault = 1'b0;
    logic        ack = 1'b0;
    logic        clear = 1'b0;
    logic        req;
    logic [1:0]  fr;
    logic [2:0]  perm;
    logic        halt;
    logic [15:0] fc;

    int total = 0;
    int passed = 0;

    cv32e40p_ft_fault_manager dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .valid_i          (valid),
        .a_i              (a),
        .b_i              (b),
        .c_i              (c),
        .winner_i         (winner),
        .fault_i          (fault),
        .resync_ack_i     (ack),
        .clear_i          (clear),
        .resync_req_o     (req),
        .faulty_replica_o (fr),
        .permanent_o      (perm),
        .halt_o           (halt),
        .fault_count_o    (fc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] va, vb, vc, vw, input logic f);
        valid = 1'b1; a = va; b = vb; c = vc; winner = vw; fault = f;
    endtask

    task automatic clean_cycles(input int n);
        drive(8, 8, 8, 8, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        valid = 1'b0; ack = 1'b0; clear = 1'b0; fault = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (req !== 1'b0) $display("FAIL reset_req got %b exp 0", req); else passed++;
        total++; if (fr !== 2'd3) $display("FAIL reset_fr got %0d exp 3", fr); else passed++;
        total++; if (perm !== 3'b000) $display("FAIL reset_perm got %b exp 000", perm); else passed++;
        total++; if (halt !== 1'b0) $display("FAIL reset_halt got %b exp 0", halt); else passed++;
        total++; if (fc !== 16'd0) $display("FAIL reset_fc got %0d exp 0", fc); else passed++;
        drive(8, 8, 8, 8, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            total++; if (req !== 1'b0) $display("FAIL clean_req cyc %0d got %b exp 0", i, req); else passed++;
        end
        total++; if ({fr, perm, halt} !== {2'd3, 3'b000, 1'b0}) $display("FAIL clean_outs got fr=%0d perm=%b halt=%b exp 3/000/0", fr, perm, halt); else passed++;
        total++; if (fc !== 16'd0) $display("FAIL clean_fc got %0d exp 0", fc); else passed++;
    endtask

    task automatic test_single_fault();
        do_reset();
        drive(8, 16, 8, 8, 1'b1);
        tick();
        total++; if (fr !== 2'd1) $display("FAIL single_fr got %0d exp 1", fr); else passed++;
        total++; if (req !== 1'b1) $display("FAIL single_req got %b exp 1", req); else passed++;
        total++; if (fc !== 16'd1) $display("FAIL single_fc got %0d exp 1", fc); else passed++;
        drive(8, 8, 8, 8, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (req !== 1'b1) $display("FAIL single_req_hold cyc %0d got %b exp 1", i, req); else passed++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++; if (req !== 1'b0) $display("FAIL single_req_ack got %b exp 0", req); else passed++;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++; if ({req, halt, fc} !== {1'b0, 1'b0, 16'd1}) $display("FAIL idle_ack_ignored got req=%b halt=%b fc=%0d exp 0/0/1", req, halt, fc); else passed++;
    endtask

    task automatic test_permanent();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            total++; if (perm !== 3'b000) $display("FAIL perm_early fault %0d got %b exp 000", i, perm); else passed++;
            drive(8, 16, 8, 8, 1'b1);
            tick();
            if (i < 3) clean_cycles(7);
        end
        total++; if (perm !== 3'b010) $display("FAIL perm_set got %b exp 010", perm); else passed++;
        total++; if (dut.cnt_q[1] !== 4'd4) $display("FAIL perm_cnt got %0d exp 4", dut.cnt_q[1]); else passed++;
        clean_cycles(8);
        total++; if (dut.cnt_q[1] !== 4'd4) $display("FAIL perm_no_decay got %0d exp 4", dut.cnt_q[1]); else passed++;
        total++; if ({perm, fc, req} !== {3'b010, 16'd4, 1'b1}) $display("FAIL perm_after got perm=%b fc=%0d req=%b exp 010/4/1", perm, fc, req); else passed++;
    endtask

    task automatic test_decay();
        do_reset();
        drive(8, 16, 8, 8, 1'b1);
        tick();
        tick();
        total++; if (dut.cnt_q[1] !== 4'd2) $display("FAIL b2b_cnt got %0d exp 2", dut.cnt_q[1]); else passed++;
        total++; if (fc !== 16'd2) $display("FAIL b2b_fc got %0d exp 2", fc); else passed++;
        clean_cycles(7);
        total++; if (dut.cnt_q[1] !== 4'd2) $display("FAIL decay_early got %0d exp 2", dut.cnt_q[1]); else passed++;
        drive(1, 2, 3, 4, 1'b0);
        valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++; if ({dut.cnt_q[1], fc} !== {4'd2, 16'd2}) $display("FAIL invalid_hold got cnt=%0d fc=%0d exp 2/2", dut.cnt_q[1], fc); else passed++;
        clean_cycles(1);
        total++; if (dut.cnt_q[1] !== 4'd1) $display("FAIL decay_first got %0d exp 1", dut.cnt_q[1]); else passed++;
        clean_cycles(8);
        total++; if (dut.cnt_q[1] !== 4'd0) $display("FAIL decay_zero got %0d exp 0", dut.cnt_q[1]); else passed++;
        drive(8, 16, 8, 8, 1'b1);
        tick();
        tick();
        total++; if (perm !== 3'b000) $display("FAIL decay_perm got %b exp 000", perm); else passed++;
        total++; if (fc !== 16'd4) $display("FAIL decay_fc got %0d exp 4", fc); else passed++;
    endtask

    task automatic test_halt();
        do_reset();
        drive(8, 12, 18, 8, 1'b1);
        tick();
        total++; if ({halt, req} !== 2'b10) $display("FAIL halt_set got halt=%b req=%b exp 1/0", halt, req); else passed++;
        total++; if (fc !== 16'd1) $display("FAIL halt_fc got %0d exp 1", fc); else passed++;
        drive(8, 16, 8, 8, 1'b1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++; if ({halt, req, fc} !== {1'b1, 1'b0, 16'd2}) $display("FAIL halt_count got halt=%b req=%b fc=%0d exp 1/0/2", halt, req, fc); else passed++;
        drive(8, 16, 8, 8, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++; if ({halt, req, fc} !== {1'b0, 1'b0, 16'd2}) $display("FAIL clear got halt=%b req=%b fc=%0d exp 0/0/2", halt, req, fc); else passed++;
        total++; if ({perm, dut.cnt_q[1]} !== {3'b000, 4'd0}) $display("FAIL clear_state got perm=%b cnt=%0d exp 000/0", perm, dut.cnt_q[1]); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(8, 8, 8, 8, 1'b1);
        tick();
        total++; if ({halt, fc} !== {1'b1, 16'd1}) $display("FAIL incons_halt got halt=%b fc=%0d exp 1/1", halt, fc); else passed++;
        do_reset();
        drive(8, 16, 8, 8, 1'b0);
        tick();
        total++; if ({halt, req} !== 2'b10) $display("FAIL unflagged_halt got halt=%b req=%b exp 1/0", halt, req); else passed++;
        do_reset();
        drive(4, 8, 8, 8, 1'b1);
        tick();
        total++; if ({req, fr, fc} !== {1'b1, 2'd0, 16'd1}) $display("FAIL afault got req=%b fr=%0d fc=%0d exp 1/0/1", req, fr, fc); else passed++;
        clean_cycles(1);
        drive(4, 8, 8, 8, 1'b1);
        ack = 1'b1;
        tick();
        total++; if ({req, fc} !== {1'b1, 16'd2}) $display("FAIL ack_fault got req=%b fc=%0d exp 1/2", req, fc); else passed++;
        total++; if (dut.cnt_q[0] !== 4'd2) $display("FAIL ack_fault_cnt got %0d exp 2", dut.cnt_q[0]); else passed++;
        drive(8, 8, 8, 8, 1'b0);
        tick();
        ack = 1'b0;
        total++; if (req !== 1'b0) $display("FAIL ack_release got %b exp 0", req); else passed++;
        drive(8, 8, 18, 8, 1'b1);
        tick();
        total++; if ({req, fr} !== {1'b1, 2'd2}) $display("FAIL cfault got req=%b fr=%0d exp 1/2", req, fr); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if ({req, fc, fr} !== {1'b0, 16'd0, 2'd3}) $display("FAIL async_reset got req=%b fc=%0d fr=%0d exp 0/0/3", req, fc, fr); else passed++;
        rst = 1'b0;
        valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fault();
        test_permanent();
        test_decay();
        test_halt();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
